hazard_unit: RTL and testbench

Pipeline hazard controller: the producer of the flush, stall and forwarding controls that the ID/EX pipeline register and the IF/ID register consume. It keeps a shadow tag pipeline of the destination registers in flight (EX, MEM, WB) and compares them against the ID-stage source registers. From that it drives operand forwarding, inserts load-use bubbles and squashes wrong-path instructions on a branch/jump redirect resolved in EX. It also keeps saturating stall/flush performance counters.

---
 rtl/hazard_unit_pkg.sv | 24 ++
 rtl/hazard_unit_if.sv | 44 ++++
 rtl/hz_fwd_sel.sv | 55 +++++
 rtl/hazard_unit.sv | 119 +++++++++++
 tb/tb_hazard_unit.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: writeback-select encodings
// and the shadow destination tags that follow instructions through EX/MEM/WB.
package hazard_unit_pkg;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_IMM  = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } dst_t;

  // is_load only matters while the writer sits in EX; it is dropped past EX
  typedef struct packed {
    dst_t dst;
    logic is_load;
  } tag_t;

  localparam dst_t DST_INVALID = '{valid: 1'b0, rd: 5'd0};
  localparam tag_t TAG_INVALID = '{dst: DST_INVALID, is_load: 1'b0};

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard controller bus: ID-stage decode/writeback values in, pipeline
// stall/flush/forward controls and performance counters out.
interface hazard_unit_if #(parameter int CNT_W = 32);

  logic             instr_valid_id_i;
  logic [4:0]       rs1_id_i;
  logic [4:0]       rs2_id_i;
  logic             rs1_used_id_i;
  logic             rs2_used_id_i;
  logic [4:0]       wr_id_i;
  logic             rf_we_id_i;
  logic [1:0]       wd_sel_id_i;
  logic [31:0]      wb_data_ex_i;
  logic [31:0]      wb_data_mem_i;
  logic [31:0]      wb_data_wb_i;
  logic             redirect_ex_i;
  logic             stall_if_o;
  logic             stall_id_o;
  logic             flush_if_id_o;
  logic             flush_id_ex_o;
  logic             fwd_rD1e_o;
  logic             fwd_rD2e_o;
  logic [31:0]      fwd_rD1_o;
  logic [31:0]      fwd_rD2_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output instr_valid_id_i, rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i,
           wr_id_i, rf_we_id_i, wd_sel_id_i, wb_data_ex_i, wb_data_mem_i,
           wb_data_wb_i, redirect_ex_i,
    input  stall_if_o, stall_id_o, flush_if_id_o, flush_id_ex_o, fwd_rD1e_o,
           fwd_rD2e_o, fwd_rD1_o, fwd_rD2_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  instr_valid_id_i, rs1_id_i, rs2_id_i, rs1_used_id_i, rs2_used_id_i,
           wr_id_i, rf_we_id_i, wd_sel_id_i, wb_data_ex_i, wb_data_mem_i,
           wb_data_wb_i, redirect_ex_i,
    output stall_if_o, stall_id_o, flush_if_id_o, flush_id_ex_o, fwd_rD1e_o,
           fwd_rD2e_o, fwd_rD1_o, fwd_rD2_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/hz_fwd_sel.sv
// Per-operand forwarding matcher: youngest in-flight writer wins, and a load
// still in EX is reported as a load-use hazard instead of being forwarded.
module hz_fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic [4:0]  rs,
  input  logic        used,
  input  logic        id_valid,
  input  tag_t        ex_tag,
  input  dst_t        mem_dst,
  input  dst_t        wb_dst,
  input  logic [31:0] data_ex,
  input  logic [31:0] data_mem,
  input  logic [31:0] data_wb,
  output logic        fwd_en,
  output logic        load_use,
  output logic [31:0] data
);

  logic rd_ok_s;
  logic hit_ex_s;
  logic hit_mem_s;
  logic hit_wb_s;

  assign rd_ok_s   = used & id_valid & (rs != 5'd0);
  assign hit_ex_s  = rd_ok_s & ex_tag.dst.valid & (ex_tag.dst.rd == rs);
  assign hit_mem_s = rd_ok_s & mem_dst.valid & (mem_dst.rd == rs);
  assign hit_wb_s  = rd_ok_s & wb_dst.valid & (wb_dst.rd == rs);

  // Priority select EX > MEM > WB
  always_comb begin
    fwd_en   = 1'b0;
    load_use = 1'b0;
    data     = 32'd0;
    if (hit_ex_s) begin
      if (ex_tag.is_load) begin
        load_use = 1'b1;
      end else begin
        fwd_en = 1'b1;
        data   = data_ex;
      end
    end else if (hit_mem_s) begin
      fwd_en = 1'b1;
      data   = data_mem;
    end else if (hit_wb_s) begin
      fwd_en = 1'b1;
      data   = data_wb;
    end else begin
      fwd_en   = 1'b0;
      load_use = 1'b0;
      data     = 32'd0;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: shadow destination tags for EX/MEM/WB, operand
// forwarding, load-use bubbles, redirect squashing and saturating counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  hazard_unit_if.slave hz
);

  tag_t             ex_tag_r;
  dst_t             mem_dst_r;
  dst_t             wb_dst_r;
  tag_t             ex_tag_nxt_s;
  logic             fe1_s;
  logic             fe2_s;
  logic             lu1_s;
  logic             lu2_s;
  logic [31:0]      d1_s;
  logic [31:0]      d2_s;
  logic             load_use_s;
  logic             stall_s;
  logic             flush_id_ex_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  hz_fwd_sel u_fwd1 (
    .rs       (hz.rs1_id_i),
    .used     (hz.rs1_used_id_i),
    .id_valid (hz.instr_valid_id_i),
    .ex_tag   (ex_tag_r),
    .mem_dst  (mem_dst_r),
    .wb_dst   (wb_dst_r),
    .data_ex  (hz.wb_data_ex_i),
    .data_mem (hz.wb_data_mem_i),
    .data_wb  (hz.wb_data_wb_i),
    .fwd_en   (fe1_s),
    .load_use (lu1_s),
    .data     (d1_s)
  );

  hz_fwd_sel u_fwd2 (
    .rs       (hz.rs2_id_i),
    .used     (hz.rs2_used_id_i),
    .id_valid (hz.instr_valid_id_i),
    .ex_tag   (ex_tag_r),
    .mem_dst  (mem_dst_r),
    .wb_dst   (wb_dst_r),
    .data_ex  (hz.wb_data_ex_i),
    .data_mem (hz.wb_data_mem_i),
    .data_wb  (hz.wb_data_wb_i),
    .fwd_en   (fe2_s),
    .load_use (lu2_s),
    .data     (d2_s)
  );

  // A redirect squashes the stalled instruction anyway, so it wins over load-use
  assign load_use_s    = lu1_s | lu2_s;
  assign stall_s       = load_use_s & ~hz.redirect_ex_i;
  assign flush_id_ex_s = load_use_s | hz.redirect_ex_i;

  assign hz.stall_if_o    = stall_s;
  assign hz.stall_id_o    = stall_s;
  assign hz.flush_if_id_o = hz.redirect_ex_i;
  assign hz.flush_id_ex_o = flush_id_ex_s;
  assign hz.fwd_rD1e_o    = fe1_s;
  assign hz.fwd_rD2e_o    = fe2_s;
  assign hz.fwd_rD1_o     = d1_s;
  assign hz.fwd_rD2_o     = d2_s;
  assign hz.stall_cnt_o   = stall_cnt_r;
  assign hz.flush_cnt_o   = flush_cnt_r;

  // Tag entering EX: a bubble whenever ID/EX is flushed
  always_comb begin
    ex_tag_nxt_s = TAG_INVALID;
    if (flush_id_ex_s) begin
      ex_tag_nxt_s = TAG_INVALID;
    end else begin
      ex_tag_nxt_s.dst.valid = hz.instr_valid_id_i & hz.rf_we_id_i & (hz.wr_id_i != 5'd0);
      ex_tag_nxt_s.dst.rd    = hz.wr_id_i;
      ex_tag_nxt_s.is_load   = (hz.wd_sel_id_i == WD_DRAM);
    end
  end

  // Shadow tag pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_tag_r  <= TAG_INVALID;
      mem_dst_r <= DST_INVALID;
      wb_dst_r  <= DST_INVALID;
    end else begin
      ex_tag_r  <= ex_tag_nxt_s;
      mem_dst_r <= ex_tag_r.dst;
      wb_dst_r  <= mem_dst_r;
    end
  end

  // Saturating stall/flush performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (stall_s && (stall_cnt_r != '1)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (hz.redirect_ex_i && (flush_cnt_r != '1)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a cycle-by-cycle vector table plus hand
// sequences for reset mid-stall and counter saturation on a 4-bit instance.
module tb_hazard_unit;
  import hazard_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  hazard_unit_if #(.CNT_W(32)) hz ();
  hazard_unit_if #(.CNT_W(4))  hz4 ();

  hazard_unit #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .hz(hz.slave));
  hazard_unit #(.CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .hz(hz4.slave));

  assign hz4.instr_valid_id_i = hz.instr_valid_id_i;
  assign hz4.rs1_id_i         = hz.rs1_id_i;
  assign hz4.rs2_id_i         = hz.rs2_id_i;
  assign hz4.rs1_used_id_i    = hz.rs1_used_id_i;
  assign hz4.rs2_used_id_i    = hz.rs2_used_id_i;
  assign hz4.wr_id_i          = hz.wr_id_i;
  assign hz4.rf_we_id_i       = hz.rf_we_id_i;
  assign hz4.wd_sel_id_i      = hz.wd_sel_id_i;
  assign hz4.wb_data_ex_i     = hz.wb_data_ex_i;
  assign hz4.wb_data_mem_i    = hz.wb_data_mem_i;
  assign hz4.wb_data_wb_i     = hz.wb_data_wb_i;
  assign hz4.redirect_ex_i    = hz.redirect_ex_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  wr;
    logic        we;
    logic [1:0]  ws;
    logic        rd;
    logic [31:0] dex, dmem, dwb;
    logic        st, fif, fie, fe1, fe2;
    logic [31:0] d1, d2, sc, fc;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] wr,
                       input logic we, input logic [1:0] ws, input logic rd,
                       input logic [31:0] dex, input logic [31:0] dmem, input logic [31:0] dwb);
    hz.instr_valid_id_i = v;
    hz.rs1_id_i = rs1;  hz.rs2_id_i = rs2;
    hz.rs1_used_id_i = u1;  hz.rs2_used_id_i = u2;
    hz.wr_id_i = wr;  hz.rf_we_id_i = we;  hz.wd_sel_id_i = ws;
    hz.redirect_ex_i = rd;
    hz.wb_data_ex_i = dex;  hz.wb_data_mem_i = dmem;  hz.wb_data_wb_i = dwb;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall_if"}, {31'd0, hz.stall_if_o}, 32'd0);
    chk({tag, ".stall_id"}, {31'd0, hz.stall_id_o}, 32'd0);
    chk({tag, ".flush_if_id"}, {31'd0, hz.flush_if_id_o}, 32'd0);
    chk({tag, ".flush_id_ex"}, {31'd0, hz.flush_id_ex_o}, 32'd0);
    chk({tag, ".fwd1e"}, {31'd0, hz.fwd_rD1e_o}, 32'd0);
    chk({tag, ".fwd2e"}, {31'd0, hz.fwd_rD2e_o}, 32'd0);
    chk({tag, ".fwd1"}, hz.fwd_rD1_o, 32'd0);
    chk({tag, ".fwd2"}, hz.fwd_rD2_o, 32'd0);
    chk({tag, ".stall_cnt"}, hz.stall_cnt_o, 32'd0);
    chk({tag, ".flush_cnt"}, hz.flush_cnt_o, 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    // v rs1 rs2 u1 u2 wr we ws rd dex dmem dwb | st fif fie fe1 fe2 d1 d2 sc fc
    vecs[0]  = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, WD_ALU,  1'b0, 32'h0,  32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'd0, 32'd0};
    vecs[1]  = '{1'b1, 5'd0,  5'd0, 1'b0, 1'b0, 5'd5,  1'b1, WD_ALU,  1'b0, 32'h0,  32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'd0, 32'd0};
    vecs[2]  = '{1'b1, 5'd5,  5'd0, 1'b1, 1'b0, 5'd0,  1'b0, WD_ALU,  1'b0, 32'h11, 32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 32'h0,    32'd0, 32'd0};
    vecs[3]  = '{1'b1, 5'd0,  5'd5, 1'b0, 1'b1, 5'd0,  1'b0, WD_ALU,  1'b0, 32'h0,  32'h22,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h22,   32'd0, 32'd0};
    vecs[4]  = '{1'b1, 5'd5,  5'd5, 1'b1, 1'b1, 5'd6,  1'b1, WD_DRAM, 1'b0, 32'h0,  32'h0,    32'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 32'h33,   32'd0, 32'd0};
    vecs[5]  = '{1'b1, 5'd0,  5'd6, 1'b0, 1'b1, 5'd0,  1'b0, WD_ALU,  1'b0, 32'h0,  32'h0,    32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,    32'd0, 32'd0};
    vecs[6]  = '{1'b1, 5'd0,  5'd6, 1'b0, 1'b1, 5'd7,  1'b1, WD_ALU,  1'b0, 32'h0,  32'hCAFE, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'hCAFE, 32'd1, 32'd0};
    vecs[7]  = '{1'b1, 5'd6,  5'd0, 1'b1, 1'b0, 5'd7,  1'b1, WD_ALU,  1'b0, 32'h0,  32'h0,    32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0,    32'd1, 32'd0};
    vecs[8]  = '{1'b1, 5'd0,  5'd0, 1'b0, 1'b0, 5'd7,  1'b1, WD_ALU,  1'b0, 32'h0,  32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'd1, 32'd0};
    vecs[9]  = '{1'b1, 5'd7,  5'd0, 1'b1, 1'b0, 5'd0,  1'b0, WD_ALU,  1'b0, 32'h1,  32'h2,    32'h3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1,  32'h0,    32'd1, 32'd0};
    vecs[10] = '{1'b1, 5'd7,  5'd0, 1'b1, 1'b0, 5'd9,  1'b1, WD_DRAM, 1'b0, 32'h1,  32'h2,    32'h3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2,  32'h0,    32'd1, 32'd0};
    vecs[11] = '{1'b1, 5'd9,  5'd0, 1'b1, 1'b0, 5'd10, 1'b1, WD_ALU,  1'b1, 32'h0,  32'h0,    32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,    32'd1, 32'd0};
    vecs[12] = '{1'b1, 5'd10, 5'd9, 1'b1, 1'b1, 5'd0,  1'b0, WD_ALU,  1'b0, 32'h77, 32'h55,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,  32'h55,   32'd1, 32'd1};
    vecs[13] = '{1'b1, 5'd0,  5'd0, 1'b1, 1'b0, 5'd0,  1'b1, WD_ALU,  1'b0, 32'h0,  32'h0,    32'h66, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'd1, 32'd1};
    vecs[14] = '{1'b1, 5'd0,  5'd0, 1'b1, 1'b1, 5'd12, 1'b1, WD_ALU,  1'b0, 32'h99, 32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'd1, 32'd1};
    vecs[15] = '{1'b0, 5'd12, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, WD_ALU,  1'b0, 32'hAA, 32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'd1, 32'd1};
    vecs[16] = '{1'b1, 5'd13, 5'd12,1'b1, 1'b1, 5'd0,  1'b0, WD_ALU,  1'b1, 32'h0,  32'hBB,   32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,  32'hBB,   32'd1, 32'd1};
    vecs[17] = '{1'b1, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, WD_ALU,  1'b1, 32'h0,  32'h0,    32'h0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,    32'd1, 32'd2};
    vecs[18] = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  1'b0, WD_ALU,  1'b0, 32'h0,  32'h0,    32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    32'd1, 32'd3};

    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, WD_ALU, 1'b0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].wr,
            vecs[i].we, vecs[i].ws, vecs[i].rd, vecs[i].dex, vecs[i].dmem, vecs[i].dwb);
      #2;
      chk($sformatf("v%0d.stall_if", i),    {31'd0, hz.stall_if_o},    {31'd0, vecs[i].st});
      chk($sformatf("v%0d.stall_id", i),    {31'd0, hz.stall_id_o},    {31'd0, vecs[i].st});
      chk($sformatf("v%0d.flush_if_id", i), {31'd0, hz.flush_if_id_o}, {31'd0, vecs[i].fif});
      chk($sformatf("v%0d.flush_id_ex", i), {31'd0, hz.flush_id_ex_o}, {31'd0, vecs[i].fie});
      chk($sformatf("v%0d.fwd1e", i),       {31'd0, hz.fwd_rD1e_o},    {31'd0, vecs[i].fe1});
      chk($sformatf("v%0d.fwd2e", i),       {31'd0, hz.fwd_rD2e_o},    {31'd0, vecs[i].fe2});
      chk($sformatf("v%0d.fwd1", i),        hz.fwd_rD1_o,              vecs[i].d1);
      chk($sformatf("v%0d.fwd2", i),        hz.fwd_rD2_o,              vecs[i].d2);
      chk($sformatf("v%0d.stall_cnt", i),   hz.stall_cnt_o,            vecs[i].sc);
      chk($sformatf("v%0d.flush_cnt", i),   hz.flush_cnt_o,            vecs[i].fc);
      @(negedge clk);
    end

    // Reset asserted while a load-use stall is active
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, WD_DRAM, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, WD_ALU, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    chk("rst_mid.stall_before", {31'd0, hz.stall_if_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("rst_release");
    @(negedge clk);
    #1;
    chk_all_zero("rst_after");

    // Repeated lw/use pairs: 32-bit counter tracks, 4-bit counter pins at 0xF
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, WD_DRAM, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      drive(1'b1, 5'd0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, WD_ALU, 1'b0, 32'h0, 32'h0, 32'h0);
      #1;
      chk($sformatf("sat%0d.stall", k), {31'd0, hz4.stall_if_o}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.cnt32", k), hz.stall_cnt_o, k);
      chk($sformatf("sat%0d.cnt4", k), {28'd0, hz4.stall_cnt_o}, (k > 15) ? 32'd15 : k);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
